score_keeper: RTL and testbench

Upstream feeder of the four-digit `sevenSegment` display in the ping-pong design.
- Counts points for players A and B from single-cycle pulses issued by the game logic.
- Applies win rules (first to `WIN_SCORE`, win by 2) and tracks which player serves.
- Presents both scores as four BCD digits on `num0`–`num3`, the exact inputs of the TDM display stage.

---
 rtl/score_pkg.sv | 22 ++
 rtl/bcd_counter2.sv | 49 ++++
 rtl/score_keeper.sv | 109 ++++++++++
 tb/tb_score_keeper.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared types and defaults for the ping-pong score keeper.
package score_pkg;

    typedef enum logic {
        PLAY = 1'b0,
        OVER = 1'b1
    } state_e;

    typedef enum logic {
        PLAYER_A = 1'b0,
        PLAYER_B = 1'b1
    } player_e;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd2_t;

    localparam int DEF_WIN_SCORE = 11;
    localparam int DEF_MAX_SCORE = 99;

endpackage

// File: rtl/bcd_counter2.sv
// Two-digit BCD counter with a binary mirror kept in lock-step.
module bcd_counter2
    import score_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       inc,
    input  logic       hold,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic [6:0] value
);

    bcd2_t      bcd_q, bcd_d;
    logic [6:0] bin_q, bin_d;

    always_comb begin
        bcd_d = bcd_q;
        bin_d = bin_q;
        if (clr) begin
            bcd_d = '0;
            bin_d = '0;
        end else if (inc && !hold) begin
            bin_d = bin_q + 7'd1;
            if (bcd_q.ones == 4'd9) begin
                bcd_d.ones = 4'd0;
                bcd_d.tens = (bcd_q.tens == 4'd9) ? 4'd0 : bcd_q.tens + 4'd1;
            end else begin
                bcd_d.ones = bcd_q.ones + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bcd_q <= '0;
            bin_q <= '0;
        end else begin
            bcd_q <= bcd_d;
            bin_q <= bin_d;
        end
    end

    assign tens  = bcd_q.tens;
    assign ones  = bcd_q.ones;
    assign value = bin_q;

endmodule

// File: rtl/score_keeper.sv
// Ping-pong scoring: win rules, serve rotation and BCD digits for the display.
module score_keeper
    import score_pkg::*;
#(
    parameter int WIN_SCORE = DEF_WIN_SCORE,
    parameter int MAX_SCORE = DEF_MAX_SCORE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       point_a,
    input  logic       point_b,
    input  logic       new_game,
    output logic [3:0] num0,
    output logic [3:0] num1,
    output logic [3:0] num2,
    output logic [3:0] num3,
    output logic       serve_a,
    output logic       game_over,
    output logic       winner
);

    localparam logic [7:0] WIN_L  = 8'(WIN_SCORE);
    localparam logic [7:0] DEUCE  = 8'(WIN_SCORE - 1);
    localparam logic [6:0] MAX_L  = 7'(MAX_SCORE);

    state_e     state_q, state_d;
    player_e    winner_q, winner_d;
    logic       serve_q, serve_d;
    logic       over_q, over_d;

    logic [6:0] score_a, score_b;
    logic       cnt_a, cnt_b;
    logic       max_a, max_b;
    logic [7:0] post_a, post_b;
    logic       win_a, win_b;
    logic       deuce, even;

    bcd_counter2 u_cnt_a (
        .clk   (clk),
        .reset (reset),
        .clr   (new_game),
        .inc   (cnt_a),
        .hold  (max_a),
        .tens  (num0),
        .ones  (num1),
        .value (score_a)
    );

    bcd_counter2 u_cnt_b (
        .clk   (clk),
        .reset (reset),
        .clr   (new_game),
        .inc   (cnt_b),
        .hold  (max_b),
        .tens  (num2),
        .ones  (num3),
        .value (score_b)
    );

    always_comb begin
        cnt_a  = (state_q == PLAY) && point_a && !point_b && !new_game;
        cnt_b  = (state_q == PLAY) && point_b && !point_a && !new_game;
        max_a  = (score_a == MAX_L);
        max_b  = (score_b == MAX_L);
        post_a = {1'b0, score_a} + {7'd0, cnt_a && !max_a};
        post_b = {1'b0, score_b} + {7'd0, cnt_b && !max_b};
        // A point at the ceiling cannot be counted, so it decides the game.
        win_a  = cnt_a && (max_a || (post_a >= WIN_L && post_a >= post_b + 8'd2));
        win_b  = cnt_b && (max_b || (post_b >= WIN_L && post_b >= post_a + 8'd2));
        deuce  = (post_a >= DEUCE) && (post_b >= DEUCE);
        even   = !(post_a[0] ^ post_b[0]);

        state_d  = state_q;
        winner_d = winner_q;
        serve_d  = serve_q;
        over_d   = over_q;

        if (new_game) begin
            state_d = PLAY;
            over_d  = 1'b0;
            serve_d = (state_q == OVER) ? (winner_q == PLAYER_B) : 1'b1;
        end else if (win_a || win_b) begin
            state_d  = OVER;
            over_d   = 1'b1;
            winner_d = win_b ? PLAYER_B : PLAYER_A;
        end else if ((cnt_a || cnt_b) && (deuce || even)) begin
            serve_d = !serve_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= PLAY;
            winner_q <= PLAYER_A;
            serve_q  <= 1'b1;
            over_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            serve_q  <= serve_d;
            over_q   <= over_d;
        end
    end

    assign serve_a   = serve_q;
    assign game_over = over_q;
    assign winner    = winner_q;

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper at WIN_SCORE 11 and 98.
module tb_score_keeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rst = '0;
    logic [1:0] pa  = '0;
    logic [1:0] pb  = '0;
    logic [1:0] ng  = '0;
    logic [3:0] n0 [2];
    logic [3:0] n1 [2];
    logic [3:0] n2 [2];
    logic [3:0] n3 [2];
    logic [1:0] srv, go, win;

    score_keeper #(.WIN_SCORE(11), .MAX_SCORE(99)) dut (
        .clk(clk), .reset(rst[0]), .point_a(pa[0]), .point_b(pb[0]),
        .new_game(ng[0]), .num0(n0[0]), .num1(n1[0]), .num2(n2[0]),
        .num3(n3[0]), .serve_a(srv[0]), .game_over(go[0]), .winner(win[0])
    );

    score_keeper #(.WIN_SCORE(98), .MAX_SCORE(99)) dut98 (
        .clk(clk), .reset(rst[1]), .point_a(pa[1]), .point_b(pb[1]),
        .new_game(ng[1]), .num0(n0[1]), .num1(n1[1]), .num2(n2[1]),
        .num3(n3[1]), .serve_a(srv[1]), .game_over(go[1]), .winner(win[1])
    );

    typedef struct {
        int a;
        int b;
        bit serve;
        bit over;
        bit winner;
    } model_t;

    model_t m [2];
    int win_of [2] = '{11, 98};
    logic [18:0] q0 [$];
    logic [18:0] q1 [$];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [18:0] pack_exp(input model_t s);
        return {4'(s.a / 10), 4'(s.a % 10), 4'(s.b / 10), 4'(s.b % 10),
                s.serve, s.over, s.winner};
    endfunction

    function automatic logic [18:0] obs_vec(input int d);
        return {n0[d], n1[d], n2[d], n3[d], srv[d], go[d], win[d]};
    endfunction

    function automatic logic [15:0] digits(input int d);
        return {n0[d], n1[d], n2[d], n3[d]};
    endfunction

    task automatic model_step(input int d, input bit r, input bit a,
                              input bit b, input bit n);
        model_t s = m[d];
        int w = win_of[d];
        bit won = 0;
        if (r) begin
            s.a = 0; s.b = 0; s.serve = 1; s.over = 0; s.winner = 0;
        end else if (n) begin
            s.serve = s.over ? s.winner : 1'b1;
            s.a = 0; s.b = 0; s.over = 0;
        end else if (!s.over && (a != b)) begin
            if (a) begin
                if (s.a == 99) won = 1;
                else begin
                    s.a++;
                    won = (s.a >= w) && (s.a - s.b >= 2);
                end
            end else begin
                if (s.b == 99) won = 1;
                else begin
                    s.b++;
                    won = (s.b >= w) && (s.b - s.a >= 2);
                end
            end
            if (won) begin
                s.over = 1;
                s.winner = b;
            end else if ((s.a >= w - 1 && s.b >= w - 1) || ((s.a + s.b) % 2 == 0)) begin
                s.serve = !s.serve;
            end
        end
        m[d] = s;
    endtask

    task automatic step(input int d, input bit r, input bit a, input bit b,
                        input bit n, input string tag);
        logic [18:0] exp;
        @(negedge clk);
        rst[d] = r; pa[d] = a; pb[d] = b; ng[d] = n;
        model_step(d, r, a, b, n);
        if (d == 0) q0.push_back(pack_exp(m[d]));
        else        q1.push_back(pack_exp(m[d]));
        @(posedge clk);
        #1;
        exp = (d == 0) ? q0.pop_front() : q1.pop_front();
        check(tag, {13'd0, obs_vec(d)}, {13'd0, exp});
        rst[d] = 0; pa[d] = 0; pb[d] = 0; ng[d] = 0;
    endtask

    initial begin
        step(0, 1, 0, 0, 0, "reset");
        check("rst_digits", {16'd0, digits(0)}, 32'h0000);
        check("rst_serve", {31'd0, srv[0]}, 32'd1);
        check("rst_over", {31'd0, go[0]}, 32'd0);

        step(0, 0, 1, 0, 0, "p1");
        step(0, 0, 0, 1, 0, "p2");
        check("serve_after2", {31'd0, srv[0]}, 32'd0);
        step(0, 0, 1, 0, 0, "p3");
        step(0, 0, 0, 1, 0, "p4");
        check("serve_after4", {31'd0, srv[0]}, 32'd1);
        step(0, 0, 1, 0, 0, "p5");
        check("digits_3_2", {16'd0, digits(0)}, 32'h0302);
        check("over_3_2", {31'd0, go[0]}, 32'd0);

        step(0, 0, 0, 0, 1, "ng_abandon");
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, "b_to5");
        for (int i = 0; i < 11; i++) step(0, 0, 1, 0, 0, "a_to11");
        check("digits_11_5", {16'd0, digits(0)}, 32'h1105);
        check("over_11_5", {31'd0, go[0]}, 32'd1);
        check("winner_11_5", {31'd0, win[0]}, 32'd0);
        step(0, 0, 0, 1, 0, "frozen_b");
        check("frozen_digits", {16'd0, digits(0)}, 32'h1105);

        step(0, 0, 0, 0, 1, "ng_after_a");
        check("loser_b_serves", {31'd0, srv[0]}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 1, 0, 0, "deuce_a");
            step(0, 0, 0, 1, 0, "deuce_b");
        end
        check("digits_10_10", {16'd0, digits(0)}, 32'h1010);
        check("serve_10_10", {31'd0, srv[0]}, 32'd0);
        step(0, 0, 1, 0, 0, "d1");
        check("serve_d1", {31'd0, srv[0]}, 32'd1);
        step(0, 0, 0, 1, 0, "d2");
        check("serve_d2", {31'd0, srv[0]}, 32'd0);
        step(0, 0, 1, 0, 0, "d3");
        check("serve_d3", {31'd0, srv[0]}, 32'd1);
        step(0, 0, 1, 0, 0, "d4");
        check("serve_win", {31'd0, srv[0]}, 32'd1);
        check("digits_13_11", {16'd0, digits(0)}, 32'h1311);
        check("over_13_11", {31'd0, go[0]}, 32'd1);
        check("winner_13_11", {31'd0, win[0]}, 32'd0);

        step(0, 0, 0, 0, 1, "ng_4_4");
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1, 0, 0, "to4_a");
            step(0, 0, 0, 1, 0, "to4_b");
        end
        step(0, 0, 1, 1, 0, "both");
        check("both_digits", {16'd0, digits(0)}, 32'h0404);
        check("both_serve", {31'd0, srv[0]}, 32'd0);
        step(0, 0, 1, 0, 1, "ng_prio");
        check("ng_prio_digits", {16'd0, digits(0)}, 32'h0000);
        check("ng_prio_serve", {31'd0, srv[0]}, 32'd1);

        for (int i = 0; i < 7; i++) step(0, 0, 1, 0, 0, "a_to7");
        for (int i = 0; i < 11; i++) step(0, 0, 0, 1, 0, "b_to11");
        check("b_wins", {30'd0, go[0], win[0]}, 32'd3);
        step(0, 0, 0, 0, 1, "ng_after_b");
        check("ng_digits", {16'd0, digits(0)}, 32'h0000);
        check("ng_over", {31'd0, go[0]}, 32'd0);
        check("loser_a_serves", {31'd0, srv[0]}, 32'd1);
        for (int i = 0; i < 9; i++) step(0, 0, 1, 0, 0, "a_to9");
        check("digits_9", {16'd0, digits(0)}, 32'h0900);
        step(0, 0, 1, 0, 0, "a_to10");
        check("carry_10", {16'd0, digits(0)}, 32'h1000);
        step(0, 1, 1, 0, 1, "reset_mid");
        check("reset_mid_all", {13'd0, obs_vec(0)}, {13'd0, 16'h0000, 3'b100});

        step(1, 1, 0, 0, 0, "r98");
        for (int i = 0; i < 98; i++) begin
            step(1, 0, 1, 0, 0, "w98_a");
            step(1, 0, 0, 1, 0, "w98_b");
        end
        check("digits_98_98", {16'd0, digits(1)}, 32'h9898);
        check("over_98_98", {31'd0, go[1]}, 32'd0);
        step(1, 0, 1, 0, 0, "a99");
        check("digits_99_98", {16'd0, digits(1)}, 32'h9998);
        check("over_99_98", {31'd0, go[1]}, 32'd0);
        step(1, 0, 1, 0, 0, "ceiling");
        check("ceil_digits", {16'd0, digits(1)}, 32'h9998);
        check("ceil_over", {30'd0, go[1], win[1]}, 32'd2);
        step(1, 0, 0, 0, 1, "ng98");
        step(1, 0, 0, 1, 0, "b98");
        step(1, 1, 0, 0, 0, "reset98");
        check("reset98_all", {13'd0, obs_vec(1)}, {13'd0, 16'h0000, 3'b100});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
